// File: rtl/wiper_pkg.sv
// wiper_pkg: shared state, speed and zone encodings for the wiper controller
package wiper_pkg;
  typedef enum logic [2:0] {
    OFF      = 3'd0,
    ARM_LOW  = 3'd1,
    LOW      = 3'd2,
    ARM_HIGH = 3'd3,
    HIGH     = 3'd4,
    FAULT    = 3'd5
  } state_e;
  localparam logic [1:0] SPD_OFF  = 2'd0;
  localparam logic [1:0] SPD_LOW  = 2'd1;
  localparam logic [1:0] SPD_HIGH = 2'd3;
  typedef enum logic [1:0] {Z_NONE, Z_LO, Z_HI} zone_e;
endpackage

// File: rtl/wiper_zone_classify.sv
// wiper_zone_classify: maps a rain-drop count onto the none/low/high zones
module wiper_zone_classify
  import wiper_pkg::*;
#(
  parameter int NDROP_BITS = 6,
  parameter int LOW_ON     = 4,
  parameter int HIGH_ON    = 6
) (
  input  logic [NDROP_BITS-1:0] chuva,
  output zone_e                 zone
);
  localparam logic [NDROP_BITS-1:0] LON = NDROP_BITS'(LOW_ON);
  localparam logic [NDROP_BITS-1:0] HON = NDROP_BITS'(HIGH_ON);
  assign zone = chuva >= HON ? Z_HI : chuva >= LON ? Z_LO : Z_NONE;
endmodule

// File: rtl/wiper_ctrl_param.sv
// wiper_ctrl_param: wiper speed FSM with zone persistence, drop hysteresis,
// park request and a sticky sensor-fault state
module wiper_ctrl_param
  import wiper_pkg::*;
#(
  parameter int NDROP_BITS   = 6,
  parameter int LOW_ON       = 4,
  parameter int HIGH_ON      = 6,
  parameter int LOW_OFF      = 2,
  parameter int HIGH_OFF     = 4,
  parameter int PERSIST_LOW  = 2,
  parameter int PERSIST_HIGH = 1,
  parameter int MAX_DROPS    = 60,
  parameter int NCNT_BITS    = 2
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic [NDROP_BITS-1:0] chuva,
  input  logic                  enable,
  output logic [1:0]            limpador,
  output logic [NCNT_BITS-1:0]  cont,
  output logic [2:0]            state,
  output logic                  error
);
  localparam logic [NDROP_BITS-1:0] LOFF = NDROP_BITS'(LOW_OFF);
  localparam logic [NDROP_BITS-1:0] HOFF = NDROP_BITS'(HIGH_OFF);
  localparam logic [NDROP_BITS-1:0] MAXD = NDROP_BITS'(MAX_DROPS);
  localparam logic [NCNT_BITS-1:0]  PL   = NCNT_BITS'(PERSIST_LOW);
  localparam logic [NCNT_BITS-1:0]  PH   = NCNT_BITS'(PERSIST_HIGH);
  localparam logic [NCNT_BITS-1:0]  ONE  = NCNT_BITS'(1);
  if (!(LOW_OFF <= LOW_ON && LOW_ON <= HIGH_ON && HIGH_OFF <= HIGH_ON && HIGH_ON <= MAX_DROPS
        && PERSIST_LOW >= 1 && PERSIST_HIGH >= 1
        && PERSIST_LOW < (1 << NCNT_BITS) && PERSIST_HIGH < (1 << NCNT_BITS))) begin : g_bad_params
    $error("wiper_ctrl_param: inconsistent thresholds or persistence settings");
  end
  state_e                 state_q, state_d;
  logic [1:0]             limp_q, limp_d;
  logic [NCNT_BITS-1:0]   cont_q, cont_d;
  logic                   err_q, err_d;
  zone_e                  zone;
  logic                   fault;
  wiper_zone_classify #(.NDROP_BITS(NDROP_BITS), .LOW_ON(LOW_ON), .HIGH_ON(HIGH_ON)) u_zone (
    .chuva (chuva),
    .zone  (zone)
  );
  assign fault = chuva > MAXD;
  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q <= OFF;
      limp_q  <= SPD_OFF;
      cont_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      limp_q  <= limp_d;
      cont_q  <= cont_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (fault) state_d = FAULT;
    else if (state_q == FAULT) state_d = FAULT;
    else if (!enable) state_d = OFF;
    else
      case (state_q)
        OFF:      state_d = zone == Z_HI ? ARM_HIGH : zone == Z_LO ? ARM_LOW : OFF;
        ARM_LOW:  state_d = zone == Z_HI ? ARM_HIGH : zone == Z_NONE ? OFF : cont_q < PL ? ARM_LOW : LOW;
        LOW:      state_d = chuva < LOFF ? OFF : zone == Z_HI ? ARM_HIGH : LOW;
        ARM_HIGH: state_d = zone != Z_HI ? (limp_q == SPD_OFF ? OFF : LOW) : cont_q < PH ? ARM_HIGH : HIGH;
        HIGH:     state_d = chuva < HOFF ? LOW : HIGH;
        default:  state_d = FAULT;
      endcase
  end
  always_comb begin
    limp_d = limp_q;
    cont_d = '0;
    err_d  = err_q | fault;
    if (fault) limp_d = SPD_HIGH;
    else if (state_q == FAULT) limp_d = limp_q;
    else if (!enable) limp_d = SPD_OFF;
    else
      case (state_q)
        OFF:      cont_d = zone != Z_NONE ? ONE : '0;
        ARM_LOW: begin
          cont_d = zone == Z_HI ? ONE : zone == Z_LO && cont_q < PL ? cont_q + 1'b1 : '0;
          limp_d = zone == Z_LO && cont_q >= PL ? SPD_LOW : limp_q;
        end
        LOW: begin
          cont_d = chuva >= LOFF && zone == Z_HI ? ONE : '0;
          limp_d = chuva < LOFF ? SPD_OFF : limp_q;
        end
        ARM_HIGH: begin
          cont_d = zone == Z_HI && cont_q < PH ? cont_q + 1'b1 : '0;
          limp_d = zone == Z_HI && cont_q >= PH ? SPD_HIGH : limp_q;
        end
        HIGH:     limp_d = chuva < HOFF ? SPD_LOW : limp_q;
        default:  limp_d = limp_q;
      endcase
  end
  assign limpador = limp_q;
  assign cont     = cont_q;
  assign state    = state_q;
  assign error    = err_q;
endmodule

// File: tb/tb_wiper_ctrl_param.sv
// tb_wiper_ctrl_param: scoreboard bench; each driven cycle queues the expected
// registered outputs, a monitor pops and compares them after the edge
module tb_wiper_ctrl_param;
  import wiper_pkg::*;
  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [1:0] lp;
    logic [1:0] ct;
    logic       er;
  } exp_t;
  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] chuva = '0;
  logic       enable = 1'b1;
  logic [1:0] limpador;
  logic [1:0] cont;
  logic [2:0] state;
  logic       error;
  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  wiper_ctrl_param dut (
    .clk_2    (clk_2),
    .reset    (reset),
    .chuva    (chuva),
    .enable   (enable),
    .limpador (limpador),
    .cont     (cont),
    .state    (state),
    .error    (error)
  );
  always #5 clk_2 = ~clk_2;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic rs, input int c, input logic en,
                      input state_e st, input int lp, input int ct, input logic er);
    exp_t e;
    @(negedge clk_2);
    reset  = rs;
    chuva  = 6'(c);
    enable = en;
    e.tag = tag;
    e.st  = st;
    e.lp  = 2'(lp);
    e.ct  = 2'(ct);
    e.er  = er;
    sb.push_back(e);
  endtask
  always @(posedge clk_2) begin
    #1;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ".state"}, int'(state), int'(e.st));
      chk({e.tag, ".limpador"}, int'(limpador), int'(e.lp));
      chk({e.tag, ".cont"}, int'(cont), int'(e.ct));
      chk({e.tag, ".error"}, int'(error), int'(e.er));
    end
  end
  initial begin
    for (int i = 0; i < 3; i++) step("reset", 1, 0, 1, OFF, 0, 0, 0);
    step("lo_arm1", 0, 5, 1, ARM_LOW, 0, 1, 0);
    step("lo_arm2", 0, 5, 1, ARM_LOW, 0, 2, 0);
    step("lo_on", 0, 5, 1, LOW, 1, 0, 0);
    step("lo_park", 0, 1, 1, OFF, 0, 0, 0);
    step("re_arm1", 0, 4, 1, ARM_LOW, 0, 1, 0);
    step("re_arm2", 0, 4, 1, ARM_LOW, 0, 2, 0);
    step("re_low", 0, 4, 1, LOW, 1, 0, 0);
    step("low_hold2", 0, 2, 1, LOW, 1, 0, 0);
    step("hi_arm", 0, 7, 1, ARM_HIGH, 1, 1, 0);
    step("hi_on", 0, 7, 1, HIGH, 3, 0, 0);
    step("hi_hold4", 0, 4, 1, HIGH, 3, 0, 0);
    step("hi_drop3", 0, 3, 1, LOW, 1, 0, 0);
    step("hi_arm_b", 0, 7, 1, ARM_HIGH, 1, 1, 0);
    step("hi_abort", 0, 5, 1, LOW, 1, 0, 0);
    step("hi_arm_c", 0, 7, 1, ARM_HIGH, 1, 1, 0);
    step("hi_on_c", 0, 7, 1, HIGH, 3, 0, 0);
    step("park", 0, 7, 0, OFF, 0, 0, 0);
    step("fault_en0", 0, 63, 0, FAULT, 3, 0, 1);
    step("fault_hold1", 0, 0, 1, FAULT, 3, 0, 1);
    step("fault_hold2", 0, 5, 0, FAULT, 3, 0, 1);
    step("fault_clr", 1, 0, 1, OFF, 0, 0, 0);
    step("off_hi", 0, 60, 1, ARM_HIGH, 0, 1, 0);
    step("arm_hi_off", 0, 0, 1, OFF, 0, 0, 0);
    step("lo_none_arm", 0, 4, 1, ARM_LOW, 0, 1, 0);
    step("lo_none", 0, 3, 1, OFF, 0, 0, 0);
    step("max_ok", 0, 60, 1, ARM_HIGH, 0, 1, 0);
    step("max_fault", 0, 61, 1, FAULT, 3, 0, 1);
    step("rst2", 1, 0, 1, OFF, 0, 0, 0);
    step("mid_arm1", 0, 5, 1, ARM_LOW, 0, 1, 0);
    step("mid_arm2", 0, 5, 1, ARM_LOW, 0, 2, 0);
    step("mid_rst", 1, 5, 1, OFF, 0, 0, 0);
    step("rst_vs_fault", 1, 63, 1, OFF, 0, 0, 0);
    step("after_rst", 0, 0, 1, OFF, 0, 0, 0);
    @(posedge clk_2);
    #3;
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
